// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: pixel-tick divider, h/v counters, registered syncs; counters/syncs update on the p_tick edge, no backpressure.
// Define VGA_SYNC_POS_POL_EN for active-high hsync/vsync (default active-low).
module vga_sync_gen #(
   parameter int HD  = 640,
   parameter int HF  = 16,
   parameter int HR  = 96,
   parameter int HB  = 48,
   parameter int VD  = 480,
   parameter int VF  = 10,
   parameter int VR  = 2,
   parameter int VB  = 33,
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_tick
);

   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;

   localparam logic [9:0] H_MAX  = 10'(HT - 1);
   localparam logic [9:0] V_MAX  = 10'(VT - 1);
   localparam logic [9:0] H_ACT  = 10'(HD);
   localparam logic [9:0] V_ACT  = 10'(VD);
   localparam logic [9:0] HS_BEG = 10'(HD + HF);
   localparam logic [9:0] HS_END = 10'(HD + HF + HR - 1);
   localparam logic [9:0] VS_BEG = 10'(VD + VF);
   localparam logic [9:0] VS_END = 10'(VD + VF + VR - 1);
   localparam logic [3:0] DIV_MAX = 4'(DIV - 1);

`ifdef VGA_SYNC_POS_POL_EN
   localparam logic SYNC_ON = 1'b1;
`else
   localparam logic SYNC_ON = 1'b0;
`endif

   logic [3:0] div_cnt;
   logic [9:0] next_x;
   logic [9:0] next_y;
   logic       h_end;
   logic       v_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         div_cnt <= '0;
      else if (div_cnt == DIV_MAX)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 4'd1;
   end

   // Gated by reset so DIV=1 does not report a tick while held in reset.
   assign p_tick = reset_n & (div_cnt == DIV_MAX);

   assign h_end = (pixel_x == H_MAX);
   assign v_end = (pixel_y == V_MAX);

   always_comb begin
      next_x = h_end ? 10'd0 : pixel_x + 10'd1;
      next_y = pixel_y;
      if (h_end)
         next_y = v_end ? 10'd0 : pixel_y + 10'd1;
   end

   // Syncs are decoded from the next count so they line up with the pixel they accompany.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_x <= '0;
         pixel_y <= '0;
         hsync   <= ~SYNC_ON;
         vsync   <= ~SYNC_ON;
      end else if (p_tick) begin
         pixel_x <= next_x;
         pixel_y <= next_y;
         hsync   <= (next_x >= HS_BEG && next_x <= HS_END) ? SYNC_ON : ~SYNC_ON;
         vsync   <= (next_y >= VS_BEG && next_y <= VS_END) ? SYNC_ON : ~SYNC_ON;
      end
   end

   assign video_on   = (pixel_x < H_ACT) && (pixel_y < V_ACT);
   assign frame_tick = p_tick & h_end & v_end;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance (DIV=4) and a shrunken-timing instance (DIV=1),
// both checked every cycle against a closed-form timing model via an expected-value queue.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_POS_POL_EN
   localparam logic ACT = 1'b1;
`else
   localparam logic ACT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;

   logic       a_hs, a_vs, a_von, a_pt, a_ft;
   logic [9:0] a_x, a_y;
   logic       s_hs, s_vs, s_von, s_pt, s_ft;
   logic [9:0] s_x, s_y;

   always #5 clk = ~clk;

   vga_sync_gen dut_a (
      .clk(clk), .reset_n(reset_n), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
      .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y), .frame_tick(a_ft)
   );

   // HT = 32, VT = 15; hsync window x 20..25, vsync window y 10..11.
   vga_sync_gen #(
      .HD(16), .HF(4), .HR(6), .HB(6), .VD(8), .VF(2), .VR(2), .VB(3), .DIV(1)
   ) dut_s (
      .clk(clk), .reset_n(reset_n), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
      .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_tick(s_ft)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_clk = 0;
   logic [24:0] sb_a[$];
   logic [24:0] sb_s[$];

   bit   collect = 1'b0;
   int   hs_ticks_a = 0;
   int   vs_ticks_s = 0;
   int   ft_cnt_s = 0;
   int   von_drop_x = -1;
   int   wrap_n[$];
   logic [9:0] prev_xa = '0;
   logic prev_von_a = 1'b1;

   // Expected outputs after n clk edges since reset release, derived from the absolute tick count.
   function automatic logic [24:0] expv(input bit rst, input int n, input int div,
                                        input int hd, input int hf, input int hr, input int hb,
                                        input int vd, input int vf, input int vr, input int vb);
      int ht = hd + hf + hr + hb;
      int vt = vd + vf + vr + vb;
      int ticks, x, y;
      logic hs, vs, von, pt, ft;
      if (rst)
         return {10'd0, 10'd0, ~ACT, ~ACT, 1'b1, 1'b0, 1'b0};
      ticks = n / div;
      x   = ticks % ht;
      y   = (ticks / ht) % vt;
      pt  = ((n + 1) % div) == 0;
      hs  = (x >= hd + hf && x < hd + hf + hr) ? ACT : ~ACT;
      vs  = (y >= vd + vf && y < vd + vf + vr) ? ACT : ~ACT;
      von = (x < hd) && (y < vd);
      ft  = pt && (x == ht - 1) && (y == vt - 1);
      return {x[9:0], y[9:0], hs, vs, von, pt, ft};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp();
      sb_a.push_back(expv(!reset_n, n_clk, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      sb_s.push_back(expv(!reset_n, n_clk, 1, 16, 4, 6, 6, 8, 2, 2, 3));
   endtask

   task automatic pop_chk(input string tag);
      logic [24:0] ea, es;
      ea = sb_a.pop_front();
      es = sb_s.pop_front();
      chk({tag, "_def"}, 32'({a_x, a_y, a_hs, a_vs, a_von, a_pt, a_ft}), 32'(ea));
      chk({tag, "_small"}, 32'({s_x, s_y, s_hs, s_vs, s_von, s_pt, s_ft}), 32'(es));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (reset_n) n_clk++;
      push_exp();
      @(negedge clk);
      pop_chk(tag);
      if (collect) begin
         if (a_pt && a_hs === ACT && n_clk < 3200) hs_ticks_a++;
         if (n_clk < 480) begin
            if (s_ft) ft_cnt_s++;
            if (s_pt && s_vs === ACT) vs_ticks_s++;
         end
         if (prev_xa == 10'd799 && a_x == 10'd0) wrap_n.push_back(n_clk);
         if (von_drop_x < 0 && prev_von_a && !a_von) von_drop_x = int'(a_x);
         prev_xa    = a_x;
         prev_von_a = a_von;
      end
   endtask

   initial begin
      int k;
      reset_n = 1'b0;
      repeat (3) cycle("reset");

      reset_n = 1'b1;
      n_clk = 0;
      #1;
      push_exp();
      pop_chk("release");

      collect = 1'b1;
      repeat (6500) cycle("run");
      collect = 1'b0;

      chk("hsync_active_ticks", hs_ticks_a, 96);
      chk("vsync_active_ticks", vs_ticks_s, 64);
      chk("frame_tick_count", ft_cnt_s, 1);
      chk("line_period_clk", (wrap_n.size() >= 2) ? wrap_n[1] - wrap_n[0] : -1, 3200);
      chk("video_on_drop_x", von_drop_x, 640);

      k = 0;
      while (!(s_x == 10'd22 && s_y == 10'd10) && k < 1000) begin
         cycle("seek");
         k++;
      end
      chk("reach_mid_frame", 32'(s_x == 10'd22 && s_y == 10'd10), 1);

      // Drop reset between edges; outputs must return before the next edge.
      #2 reset_n = 1'b0;
      #1;
      push_exp();
      pop_chk("async_rst");
      n_clk = 0;
      repeat (3) cycle("hold_rst");

      reset_n = 1'b1;
      #1;
      push_exp();
      pop_chk("rerelease");
      repeat (3) cycle("restart");
      chk("x_before_first_tick", a_x, 0);
      cycle("restart");
      chk("x_after_first_tick", a_x, 1);
      repeat (20) cycle("tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
